// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_pkg;

  typedef logic [3:0] nibble_t;

  // Logical anode state; the physical level comes from anode_level().
  localparam logic ANODE_ON  = 1'b1;
  localparam logic ANODE_OFF = 1'b0;

  function automatic int calc_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic anode_level(input logic asserted, input bit active_low);
    return asserted ^ active_low;
  endfunction

endpackage

// File: rtl/seg_scan_mux_tick.sv
// Digit-dwell prescaler: tick is high on the last count of every PRESCALE-cycle period.
module scan_tick #(
  parameter int PRESCALE = 100000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0] pcnt_d;

  assign tick = (pcnt_q == LAST);

  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) pcnt_q <= '0;
    else          pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex display scanner with frame-synchronous double buffering.
// Optional leading-zero blanking is compiled in with `define SEG_SCAN_LZB_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int PRESCALE      = 100000,
  parameter bit ACTIVE_LOW_AN = 1'b1,
  localparam int SEL_W        = calc_sel_w(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              out,
  output logic [SEL_W-1:0]        select,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DIGITS - 1);
  localparam logic             AN_IDLE  = anode_level(ANODE_OFF, ACTIVE_LOW_AN);

  logic tick;
  logic wrap;
  logic visible;
  nibble_t cur_nib;

  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pend_v_q, pend_v_d;
  nibble_t                 out_q, out_d;
  logic [SEL_W-1:0]        select_q;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    wrap_q;
  logic                    frame_done_q;

  scan_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign wrap    = tick && (idx_q == LAST_IDX);
  assign cur_nib = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
  // A digit survives if it or any more-significant nibble is non-zero.
  logic [NUM_DIGITS-1:0] lz_keep;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
    if (gi == 0) begin : g_lsd
      assign lz_keep[gi] = 1'b1;
    end else begin : g_upper
      assign lz_keep[gi] = |shadow_q[4*NUM_DIGITS-1:4*gi];
    end
  end
  assign visible = digit_en[idx_q] & lz_keep[idx_q];
`else
  assign visible = digit_en[idx_q];
`endif

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign anode_d[gi] = anode_level((idx_q == SEL_W'(gi)) && visible, ACTIVE_LOW_AN);
  end

  always_comb begin
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
    // A load landing on the wrap bypasses the pending buffer so the newest value wins.
    if (load && wrap) begin
      shadow_d = data;
      pend_v_d = 1'b0;
    end else if (load) begin
      pending_d = data;
      pend_v_d  = 1'b1;
    end else if (wrap && pend_v_q) begin
      shadow_d = pending_q;
      pend_v_d = 1'b0;
    end
    out_d = visible ? cur_nib : nibble_t'(0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      out_q        <= '0;
      select_q     <= '0;
      anode_q      <= {NUM_DIGITS{AN_IDLE}};
      wrap_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      out_q        <= out_d;
      select_q     <= idx_q;
      anode_q      <= anode_d;
      // Extra stage lines the pulse up with the cycle the outputs return to digit 0.
      wrap_q       <= wrap;
      frame_done_q <= wrap_q;
    end
  end

  assign out        = out_q;
  assign select     = select_q;
  assign anode      = anode_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed 7-segment scan controller, the parametrised successor to the fixed 8-to-1 address/data nibble mux. Holds a double-buffered copy of a packed hex value, steps through `NUM_DIGITS` digits at a programmable refresh rate, and drives the current nibble plus a one-hot anode vector to the board display. Sits between the computer's address/data display bus and the hex-to-segment decoder.

## Interface
- `NUM_DIGITS`, 8: digits scanned. Legal range 2..16.
- `PRESCALE`, 100000: clocks per digit dwell. Must be ≥1.
- `ACTIVE_LOW_AN`, 1: 1 = anode asserted low; 0 = asserted high.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `data`  in  4*NUM_DIGITS  packed nibbles; digit i = `data[4i+3:4i]`.
- `load`  in  1  capture `data` into pending buffer.
- `digit_en`  in  NUM_DIGITS  per-digit enable mask; 0 blanks that digit.
- `out`  out  4  nibble of current digit, registered.
- `select`  out  SEL_W = $clog2(NUM_DIGITS)  current digit index, registered.
- `anode`  out  NUM_DIGITS  one-hot digit strobe, polarity set by `ACTIVE_LOW_AN`.
- `frame_done`  out  1  one-cycle pulse when scan wraps to digit 0.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps. `tick` = (`pcnt` == PRESCALE-1). PRESCALE=1 gives `tick` every cycle.
- Digit index `idx` advances on `tick`, wrapping NUM_DIGITS-1 → 0. `wrap` = `tick` && `idx` == NUM_DIGITS-1.
- Double buffer:
  - `load` latches `data` into `pending` and sets `pend_v`.
  - On `wrap`, if `pend_v`, then `shadow` ← `pending` and `pend_v` is cleared.
  - `load` coincident with `wrap`: `shadow` ← `data` directly and `pend_v` is cleared. The newest value wins and is shown from the next frame.
  - Displayed data never changes mid-frame.
- Blanking: digit i is visible iff `digit_en[i]` (and the leading-zero rule, if compiled in).
- Outputs for the current `idx`:
  - Visible digit: `out` = `shadow` nibble and the anode bit is asserted.
  - Blanked digit: `out` = 0 and all anodes are inactive.
  - `select` = `idx` regardless of blanking.
- `frame_done` is registered from `wrap`.

## Timing
- Reset (`reset_n`=0 at an edge): `pcnt`=0, `idx`=0, `shadow`=0, `pending`=0, `pend_v`=0, `out`=0, `select`=0, `anode` all inactive (all 1s if ACTIVE_LOW_AN else all 0s), `frame_done`=0.
- First edge with `reset_n`=1: outputs show digit 0 of `shadow`=0, subject to `digit_en`.
- Outputs lag `idx`/`shadow` by one cycle. Each digit is displayed for exactly PRESCALE cycles.
- `frame_done` is high for one cycle, in the same cycle outputs switch to digit 0. Period is NUM_DIGITS*PRESCALE.
- A `load` becomes visible 1 cycle after the next `wrap`. Repeated `load`s within a frame: the last one wins.
- Reset asserted mid-frame discards `pending`/`shadow` and returns to reset values at that edge.
- `digit_en` is sampled combinationally into the output register every cycle and takes effect on the next edge (not frame-buffered).

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking. Digits above the highest non-zero nibble of `shadow` are blanked; digit 0 is never blanked by this rule. Result is ANDed with `digit_en`.
- Macro undefined: only `digit_en` blanks. No extra logic is synthesised.

## Structure
- Shared package `seg_pkg`:
  - `nibble_t` (4-bit typedef)
  - `ANODE_ON`/`ANODE_OFF` helper constants
  - `SEL_W` function
- Sub-module `scan_tick`: parametrised prescaler producing `tick`, with synchronous active-low reset.
- Buffer, index, blank and output logic live in `seg_scan_mux`.

## Test plan
All scenarios use NUM_DIGITS=8, PRESCALE=4, ACTIVE_LOW_AN=1 unless noted.
- Reset: hold `reset_n`=0 3 cycles → `anode`=8'hFF, `out`=0, `select`=0, `frame_done`=0. Release → `select` steps 0,1,…,7 every 4 cycles; `frame_done` pulses every 32 cycles.
- Load + frame sync: `load` with `data`=32'h1234ABCD mid-frame → display unchanged until the frame wraps; next frame digit 0 `out`=D with `anode`=8'hFE, and digit 7 `out`=1 with `anode`=8'h7F.
- Load coincident with wrap, with a pending value 32'h11111111 → `data`=32'hCAFEF00D is shown next frame; 32'h11111111 is never shown.
- Mask: `digit_en`=8'b1111_0111 → during digit 3, `anode`=8'hFF and `out`=0. Other digits are normal.
- With `SEG_SCAN_LZB_EN`, `shadow`=32'h0000_0A05 → digits 3..7 blanked, digits 0..2 shown. `shadow`=0 → only digit 0 shown, with `out`=0.
- PRESCALE=1, NUM_DIGITS=2, ACTIVE_LOW_AN=0 → `select` toggles every cycle, `anode` alternates 2'b01/2'b10, `frame_done` pulses every 2 cycles. Reset asserted mid-scan returns `anode` to 2'b00 at that edge.
